// File: rtl/fft_out_seq.sv
// fft_out_seq: sequences the FFT output packing register over one frame of butterflies.
//   clk, rst (async, active-low)
//   start, abort           : frame control (start sampled only in IDLE, abort wins everything)
//   in_valid / in_ready    : half-result handshake from the butterfly datapath (real pair, then imaginary pair)
//   reg_en / reg_sel       : packing register write enable and slot select (0 real, 1 imaginary)
//   out_valid / out_ready  : packed-word handshake to the result memory / output stream
//   bfly_idx, busy, done   : current butterfly, non-IDLE flag, registered end-of-frame pulse
module fft_out_seq #(
    parameter int NO_BFLY = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             reg_en,
    output logic             reg_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] bfly_idx,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, CAP_RE, CAP_IM, PRESENT} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NO_BFLY - 1);
    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             done_nxt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bfly_idx <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bfly_idx <= idx_nxt;
            done     <= done_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        idx_nxt   = bfly_idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    if (start) begin
                         state_nxt = CAP_RE;
                         idx_nxt   = '0;
                     end
            CAP_RE:  if (in_valid) state_nxt = CAP_IM;
            CAP_IM:  if (in_valid) state_nxt = PRESENT;
            PRESENT: if (out_ready) begin
                         state_nxt = bfly_idx == LAST ? IDLE : CAP_RE;
                         idx_nxt   = bfly_idx == LAST ? '0 : bfly_idx + 1'b1;
                         done_nxt  = bfly_idx == LAST;
                     end
            default: state_nxt = IDLE;
        endcase
        // abort overrides every other transition and suppresses the done pulse
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end
    assign in_ready  = state == CAP_RE || state == CAP_IM;
    // capture happens on the handshake edge; abort blocks a write in its own cycle
    assign reg_en    = in_ready && in_valid && !abort;
    assign reg_sel   = state == CAP_IM;
    assign out_valid = state == PRESENT;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_fft_out_seq.sv
// tb_fft_out_seq: self-checking bench for fft_out_seq with a packed-word scoreboard.
module tb_fft_out_seq;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, reg_en, reg_sel, out_valid, busy, done;
    logic [1:0]  bfly_idx;
    logic [15:0] in_data, re_q = '0, im_q = '0;
    int          cyc = 0, vectors = 0, miscompares = 0;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
    } word_t;
    word_t sb[$];

    function automatic logic [15:0] dat(int c);
        return 16'(c * 37 + 5);
    endfunction

    function automatic logic [7:0] ctl(input bit ir, input bit en, input bit sel, input bit ov,
                                       input bit bs, input bit dn, input int idx);
        return {ir, en, sel, ov, bs, dn, 2'(idx)};
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign in_data = dat(cyc);

    // packing register stand-in: slot chosen by reg_sel, written when reg_en
    always @(posedge clk) begin
        if (reg_en) begin
            if (reg_sel) im_q <= in_data;
            else         re_q <= in_data;
        end
    end

    fft_out_seq #(.NO_BFLY(4), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .reg_en(reg_en), .reg_sel(reg_sel),
        .out_valid(out_valid), .out_ready(out_ready), .bfly_idx(bfly_idx),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        word_t e;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_unexpected_word", {2'(bfly_idx), re_q, im_q}, '0);
            else begin
                e = sb.pop_front();
                check("packed_word", {bfly_idx, re_q, im_q}, {e.idx, e.re, e.im});
            end
        end
    end

    // one cycle: drive inputs, check control outputs at negedge, step past next posedge
    task automatic cy(input string tag, input bit s, input bit iv, input bit orr, input bit ab,
                      input logic [7:0] e);
        start = s; in_valid = iv; out_ready = orr; abort = ab;
        @(negedge clk);
        check(tag, {in_ready, reg_en, reg_sel, out_valid, busy, done, bfly_idx}, e);
        @(posedge clk); #1;
    endtask

    // full-rate butterfly: real, imaginary, present; s drives a stray start in the real cycle
    task automatic bf(input int b, input bit s);
        sb.push_back('{idx: 2'(b), re: dat(cyc), im: dat(cyc + 1)});
        cy("cap_re", s, 1, 1, 0, ctl(1, 1, 0, 0, 1, 0, b));
        cy("cap_im", 0, 1, 1, 0, ctl(1, 1, 1, 0, 1, 0, b));
        cy("present", 0, 1, 1, 0, ctl(0, 0, 0, 1, 1, 0, b));
    endtask

    initial begin
        // reset held, then released with nothing happening for 10 cycles
        for (int i = 0; i < 3; i++) cy("in_reset", 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cy("idle", 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 0, 0));

        // full-rate frame: out_valid at 3,6,9,12, done at 13
        cy("start", 1, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        for (int b = 0; b < 4; b++) bf(b, 0);
        cy("done", 0, 1, 1, 0, ctl(0, 0, 0, 0, 0, 1, 0));
        cy("after_done", 0, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));

        // backpressure during PRESENT of butterfly 1
        cy("bp_start", 1, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        bf(0, 0);
        sb.push_back('{idx: 2'd1, re: dat(cyc), im: dat(cyc + 1)});
        cy("bp_re", 0, 1, 1, 0, ctl(1, 1, 0, 0, 1, 0, 1));
        cy("bp_im", 0, 1, 1, 0, ctl(1, 1, 1, 0, 1, 0, 1));
        for (int i = 0; i < 5; i++) cy("bp_hold", 0, 1, 0, 0, ctl(0, 0, 0, 1, 1, 0, 1));
        cy("bp_release", 0, 1, 1, 0, ctl(0, 0, 0, 1, 1, 0, 1));
        bf(2, 0);
        bf(3, 0);
        cy("bp_done", 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 1, 0));

        // starvation in CAP_IM, then a single in_valid pulse
        cy("sv_start", 1, 0, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        cy("sv_re_wait", 0, 0, 1, 0, ctl(1, 0, 0, 0, 1, 0, 0));
        sb.push_back('{idx: 2'd0, re: dat(cyc), im: dat(cyc + 5)});
        cy("sv_re", 0, 1, 1, 0, ctl(1, 1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) cy("sv_starve", 0, 0, 1, 0, ctl(1, 0, 1, 0, 1, 0, 0));
        cy("sv_pulse", 0, 1, 1, 0, ctl(1, 1, 1, 0, 1, 0, 0));
        cy("sv_present", 0, 0, 1, 0, ctl(0, 0, 0, 1, 1, 0, 0));
        for (int b = 1; b < 4; b++) bf(b, 0);
        cy("sv_done", 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 1, 0));

        // abort with in_valid in CAP_IM of butterfly 2
        cy("ab_start", 1, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        bf(0, 0);
        bf(1, 0);
        cy("ab_re", 0, 1, 1, 0, ctl(1, 1, 0, 0, 1, 0, 2));
        cy("ab_abort", 1, 1, 1, 1, ctl(1, 0, 1, 0, 1, 0, 2));
        cy("ab_idle", 0, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        cy("ab_no_done", 0, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        cy("ab_restart", 1, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        for (int b = 0; b < 4; b++) bf(b, 0);
        cy("ab_done", 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 1, 0));

        // back-to-back frames with stray start pulses
        cy("bb_start", 1, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        bf(0, 0);
        bf(1, 1);
        bf(2, 0);
        bf(3, 1);
        cy("bb_done_start", 1, 1, 1, 0, ctl(0, 0, 0, 0, 0, 1, 0));
        bf(0, 0);
        bf(1, 0);
        bf(2, 1);
        bf(3, 0);
        cy("bb_done2", 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 1, 0));
        cy("bb_idle", 0, 0, 0, 0, ctl(0, 0, 0, 0, 0, 0, 0));

        // asynchronous reset mid-frame discards progress, no done
        cy("rs_start", 1, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        cy("rs_re", 0, 1, 1, 0, ctl(1, 1, 0, 0, 1, 0, 0));
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #2 rst = 1'b0;
        #1 check("rs_async", {in_ready, reg_en, reg_sel, out_valid, busy, done, bfly_idx}, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        cy("rs_idle", 0, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));
        cy("rs_no_done", 0, 1, 1, 0, ctl(0, 0, 0, 0, 0, 0, 0));

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_out_seq.md
# fft_out_seq

Controller that sequences the FFT output packing register across one frame of butterfly results. For each butterfly it accepts the real-part pair, then the imaginary-part pair, from the butterfly datapath with a valid/ready handshake. It drives the packing register's `enable`/`sel` so both halves land in the correct slots, then holds the packed word valid until the downstream consumer accepts it. It sits between the butterfly datapath and the output packing register, and its handshake feeds the result memory / output stream.

## Interface
- `NO_BFLY`, default 4: butterflies per frame; must be ≥ 2.
- `IDX_W`, default 2: width of butterfly index; must satisfy 2^IDX_W ≥ `NO_BFLY`.

Ports (reset `rst`: asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  async active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `abort`  in  1  synchronous frame abort; returns to IDLE from any state.
- `in_valid`  in  1  datapath presents a half-result (real pair or imaginary pair).
- `in_ready`  out  1  controller accepts a half-result this cycle.
- `reg_en`  out  1  to packing register `enable`.
- `reg_sel`  out  1  to packing register `sel`: 0 = real slots, 1 = imaginary slots.
- `out_valid`  out  1  packing register holds a complete two-complex-word result.
- `out_ready`  in  1  downstream accepts packed word.
- `bfly_idx`  out  `IDX_W`  index of butterfly being captured or presented.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last butterfly of a frame is accepted downstream.

## Operation
- FSM states: IDLE, CAP_RE, CAP_IM, PRESENT.
- IDLE:
  - `in_ready`=0, `reg_en`=0, `out_valid`=0.
  - `start`=1 → CAP_RE with `bfly_idx`=0.
- CAP_RE:
  - `in_ready`=1, `reg_sel`=0, `reg_en`=`in_valid` (combinational).
  - `in_valid`=1 → CAP_IM. Otherwise stay.
- CAP_IM:
  - `in_ready`=1, `reg_sel`=1, `reg_en`=`in_valid`.
  - `in_valid`=1 → PRESENT.
- PRESENT:
  - `out_valid`=1, `in_ready`=0, `reg_en`=0, so the packed word is frozen.
  - On `out_ready`=1:
    - If `bfly_idx`=`NO_BFLY`-1: → IDLE, `bfly_idx`←0, `done`←1 next cycle.
    - Else: `bfly_idx`←`bfly_idx`+1, → CAP_RE.
- `reg_sel`=0 in IDLE and PRESENT.
- `reg_en` is never high outside CAP_RE/CAP_IM.
- `start` while not IDLE is ignored; no queuing.
- `abort`=1 (any state) → IDLE, `bfly_idx`←0, no `done` pulse, `reg_en` forced 0 that cycle.
  - `abort` has priority over `start`, `in_valid` and `out_ready` in the same cycle.
- `done` is registered. It is high exactly one cycle: the first IDLE cycle after the final PRESENT handshake.
  - `start` in that same cycle is accepted.
- `bfly_idx` never exceeds `NO_BFLY`-1. Wrap to 0 occurs only via frame completion, abort or reset.

## Timing
- Reset (async, `rst`=0) values:
  - state IDLE, `bfly_idx`=0, `done`=0.
  - `in_ready`=0, `reg_en`=0, `reg_sel`=0, `out_valid`=0, `busy`=0.
- Reset mid-frame discards progress immediately. No `done` is emitted.
- Capture latency: the half-result is written into the packing register on the same edge where `in_valid`&&`in_ready`.
  - `reg_en`/`reg_sel` are combinational from state and `in_valid`.
- Word latency: `out_valid` rises the cycle after the imaginary-pair handshake.
- Minimum per butterfly: 3 cycles (CAP_RE, CAP_IM, PRESENT) with `in_valid` and `out_ready` held high.
  - Minimum frame: 1 (IDLE/start) + 3·`NO_BFLY` cycles; `done` one cycle later.
- Backpressure: `out_valid` stays high and `bfly_idx` stays stable while `out_ready`=0, indefinitely.
- Starvation: CAP states hold indefinitely while `in_valid`=0. `reg_en` stays 0.

## Test plan
- Reset then idle: hold `rst`=0 for 3 cycles, release, `start`=0 → all outputs 0, `bfly_idx`=0, `busy`=0 for 10 cycles.
- Full-rate frame, `NO_BFLY`=4: `start` at cycle 0, `in_valid`=`out_ready`=1 throughout.
  - `reg_sel` pattern 0,1 per butterfly; `out_valid` at cycles 3,6,9,12.
  - `bfly_idx` 0..3; `done` at cycle 13 only.
- Backpressure: hold `out_ready`=0 for 5 cycles during PRESENT of butterfly 1 → `out_valid`=1, `reg_en`=0, `bfly_idx`=1 all 5 cycles.
  - Proceeds to CAP_RE with idx 2 after `out_ready`=1.
- Starvation: `in_valid`=0 for 4 cycles in CAP_IM → `reg_en`=0, state held; single `in_valid` pulse → `reg_en`=1,`reg_sel`=1 that cycle, `out_valid` next cycle.
- Abort: assert `abort` together with `in_valid` in CAP_IM of butterfly 2 → `reg_en`=0 that cycle, next cycle IDLE, `bfly_idx`=0, no `done`; a new `start` runs a clean frame.
- Back-to-back frames: `start` asserted in the `done` cycle → second frame begins next cycle with `bfly_idx`=0; stray `start` pulses mid-frame have no effect.
